// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver feeding a small FIFO with a valid/ready byte output.
// Errors are reported as single-cycle pulses one clock after the stop sample.
module uart_rx_buffer #(
    parameter int CLKS_PER_BIT = 2500,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sh;
    logic          rx_m;
    logic          rx_s;
    logic          rx_prev;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [7:0]    mem [FIFO_DEPTH];

    logic          stop_hit;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_ok;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            sh            <= '0;
            framing_error <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        sh  <= {rx_s, sh[7:1]};
                        if (idx == 3'd7) state <= STOP;
                        else             idx   <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_END) begin
                        cnt           <= '0;
                        state         <= IDLE;
                        framing_error <= !rx_s;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The push fires on the stop-sample edge itself so valid rises one clock later.
    assign stop_hit = (state == STOP) && (cnt == BIT_END);
    assign push     = stop_hit && rx_s;
    assign valid    = (wr_ptr != rd_ptr);
    assign pop      = valid && ready;
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_ok    = push && (!full || pop);
    assign data     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            overrun <= push && full && !pop;
            if (wr_ok) begin
                mem[wr_ptr[AW-1:0]] <= sh;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule
